// File: rtl/edge_ctrl_pkg.sv
// rtl/edge_ctrl_pkg.sv - shared types and constants for the edge control sequencer
package edge_ctrl_pkg;

    // Sequencer states: wait for a frame boundary, write, read back, verify
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_EOP,
        ST_WRITE,
        ST_READ,
        ST_WAIT_RD,
        ST_CHECK
    } edge_ctrl_state_t;

    // Register address of the mode word inside the edge-detection control slave
    localparam logic [1:0] CTRL_ADDR_MODE = 2'd0;

    typedef logic [31:0] ctrl_word_t;

    // True for the two states that drive an access onto the control bus
    function automatic logic is_access(input edge_ctrl_state_t s);
        return (s == ST_WRITE) || (s == ST_READ);
    endfunction

endpackage

// File: rtl/edge_ctrl_sequencer_if.sv
// rtl/edge_ctrl_sequencer_if.sv - control-slave bus between sequencer and edge subsystem
interface edge_ctrl_sequencer_if;
    import edge_ctrl_pkg::*;

    logic [1:0] ctrl_address;
    logic       ctrl_write_n;
    ctrl_word_t ctrl_writedata;
    logic       ctrl_chipselect;
    ctrl_word_t ctrl_readdata;

    modport master (
        output ctrl_address,
        output ctrl_write_n,
        output ctrl_writedata,
        output ctrl_chipselect,
        input  ctrl_readdata
    );

    modport slave (
        input  ctrl_address,
        input  ctrl_write_n,
        input  ctrl_writedata,
        input  ctrl_chipselect,
        output ctrl_readdata
    );

endinterface

// File: rtl/edge_frame_tracker.sv
// rtl/edge_frame_tracker.sv - passive video-sink tap tracking frame boundaries and count
module edge_frame_tracker #(
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mon_valid,
    input  logic                   mon_ready,
    input  logic                   mon_sop,
    input  logic                   mon_eop,
    output logic                   frame_active,
    output logic                   eop_beat,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    logic beat;
    logic sop_beat;
    logic in_frame;

    assign beat     = mon_valid & mon_ready;
    assign sop_beat = beat & mon_sop;
    assign eop_beat = beat & mon_eop;

    // A frame starting this very beat already counts as active
    assign frame_active = in_frame | sop_beat;

    // Track whether we are between SOP and EOP; a single-beat frame leaves it clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_frame <= 1'b0;
        end else if (eop_beat) begin
            in_frame <= 1'b0;
        end else if (sop_beat) begin
            in_frame <= 1'b1;
        end
    end

    // Completed-frame counter, wraps naturally at its width
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count <= '0;
        end else if (eop_beat) begin
            frame_count <= frame_count + FRAME_CNT_W'(1);
        end
    end

endmodule

// File: rtl/edge_ctrl_sequencer.sv
// rtl/edge_ctrl_sequencer.sv - frame-synchronous write/verify sequencer for the edge control slave
module edge_ctrl_sequencer
    import edge_ctrl_pkg::*;
#(
    parameter logic [1:0] CTRL_ADDR    = CTRL_ADDR_MODE,
    parameter int         READ_LATENCY = 1,
    parameter int         MAX_RETRY    = 2,
    parameter int         FRAME_CNT_W  = 16
) (
    input  logic                   sys_clk_clk,
    input  logic                   sys_reset_reset_n,
    input  ctrl_word_t             req_mode,
    input  logic                   req_valid,
    output logic                   busy,
    output ctrl_word_t             applied_mode,
    output logic                   done_pulse,
    output logic                   err,
    output logic [FRAME_CNT_W-1:0] frame_count,
    input  logic                   mon_valid,
    input  logic                   mon_ready,
    input  logic                   mon_sop,
    input  logic                   mon_eop,
    edge_ctrl_sequencer_if.master  ctrl
);

    // Retry counter must hold 0..MAX_RETRY; latency counter holds 0..READ_LATENCY-1
    localparam int         RW       = $clog2(MAX_RETRY + 2);
    localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

    edge_ctrl_state_t state;
    edge_ctrl_state_t next_state;

    logic          frame_active;
    logic          eop_beat;
    logic          pend_valid;
    ctrl_word_t    pend_word;
    ctrl_word_t    txn_word;
    ctrl_word_t    rd_word;
    logic [RW-1:0] retry_cnt;
    logic [1:0]    lat_cnt;
    logic          start_txn;
    logic          match;
    logic          can_retry;
    logic          lat_last;
    logic          retry_step;
    logic          err_set;

    edge_frame_tracker #(
        .FRAME_CNT_W (FRAME_CNT_W)
    ) u_tracker (
        .clk          (sys_clk_clk),
        .rst_n        (sys_reset_reset_n),
        .mon_valid    (mon_valid),
        .mon_ready    (mon_ready),
        .mon_sop      (mon_sop),
        .mon_eop      (mon_eop),
        .frame_active (frame_active),
        .eop_beat     (eop_beat),
        .frame_count  (frame_count)
    );

    assign match      = (rd_word == txn_word);
    assign can_retry  = (retry_cnt < RW'(MAX_RETRY));
    assign lat_last   = (lat_cnt == LAT_LAST);
    assign done_pulse = (state == ST_CHECK) && match;
    assign retry_step = (state == ST_CHECK) && !match && can_retry;
    assign err_set    = (state == ST_CHECK) && !match && !can_retry;
    assign busy       = (state != ST_IDLE) || pend_valid;

    // State register; reset aborts any transaction in flight
    always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
        if (!sys_reset_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; start_txn marks the hand-off of the pending word into flight
    always_comb begin
        next_state = state;
        start_txn  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pend_valid) begin
                    if (!frame_active) begin
                        next_state = ST_WRITE;
                        start_txn  = 1'b1;
                    end else begin
                        next_state = ST_WAIT_EOP;
                    end
                end
            end
            ST_WAIT_EOP: begin
                if (eop_beat) begin
                    next_state = ST_WRITE;
                    start_txn  = 1'b1;
                end
            end
            ST_WRITE:   next_state = ST_READ;
            ST_READ:    next_state = ST_WAIT_RD;
            ST_WAIT_RD: begin
                if (lat_last) begin
                    next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (retry_step) begin
                    next_state = ST_WRITE;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            default:    next_state = ST_IDLE;
        endcase
    end

    // Pending request slot: latest request wins until it is taken into flight
    always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
        if (!sys_reset_reset_n) begin
            pend_valid <= 1'b0;
            pend_word  <= '0;
        end else if (req_valid) begin
            pend_valid <= 1'b1;
            pend_word  <= req_mode;
        end else if (start_txn) begin
            pend_valid <= 1'b0;
        end
    end

    // In-flight word and retry count; both are fixed for the life of a transaction
    always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
        if (!sys_reset_reset_n) begin
            txn_word  <= '0;
            retry_cnt <= '0;
        end else if (start_txn) begin
            txn_word  <= pend_word;
            retry_cnt <= '0;
        end else if (retry_step) begin
            retry_cnt <= retry_cnt + RW'(1);
        end
    end

    // Read-latency counter and read-back capture on the last wait cycle
    always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
        if (!sys_reset_reset_n) begin
            lat_cnt <= '0;
            rd_word <= '0;
        end else if (state == ST_READ) begin
            lat_cnt <= '0;
        end else if (state == ST_WAIT_RD) begin
            lat_cnt <= lat_cnt + 2'd1;
            if (lat_last) begin
                rd_word <= ctrl.ctrl_readdata;
            end
        end
    end

    // Host-visible result: verified word and sticky error
    always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
        if (!sys_reset_reset_n) begin
            applied_mode <= '0;
            err          <= 1'b0;
        end else begin
            if (done_pulse) begin
                applied_mode <= txn_word;
            end
            if (err_set) begin
                err <= 1'b1;
            end else if (req_valid) begin
                err <= 1'b0;
            end
        end
    end

    // Bus outputs registered from the next state so they line up with WRITE/READ exactly
    always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
        if (!sys_reset_reset_n) begin
            ctrl.ctrl_chipselect <= 1'b0;
            ctrl.ctrl_write_n    <= 1'b1;
            ctrl.ctrl_address    <= '0;
            ctrl.ctrl_writedata  <= '0;
        end else begin
            ctrl.ctrl_chipselect <= is_access(next_state);
            ctrl.ctrl_write_n    <= (next_state != ST_WRITE);
            ctrl.ctrl_address    <= is_access(next_state) ? CTRL_ADDR : 2'd0;
            if (next_state == ST_WRITE) begin
                ctrl.ctrl_writedata <= start_txn ? pend_word : txn_word;
            end else begin
                ctrl.ctrl_writedata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_edge_ctrl_sequencer.sv
// tb/tb_edge_ctrl_sequencer.sv - self-checking bench for edge_ctrl_sequencer
module tb_edge_ctrl_sequencer;
    import edge_ctrl_pkg::*;

    localparam int         L    = 1;
    localparam int         MAXR = 2;
    localparam logic [1:0] ADDR = 2'd0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    ctrl_word_t  req_mode = '0;
    logic        req_valid = 1'b0;
    logic        busy;
    ctrl_word_t  applied_mode;
    logic        done_pulse;
    logic        err;
    logic [15:0] frame_count;
    logic        mon_valid = 1'b0;
    logic        mon_ready = 1'b0;
    logic        mon_sop = 1'b0;
    logic        mon_eop = 1'b0;

    edge_ctrl_sequencer_if bus ();

    edge_ctrl_sequencer #(
        .CTRL_ADDR    (ADDR),
        .READ_LATENCY (L),
        .MAX_RETRY    (MAXR),
        .FRAME_CNT_W  (16)
    ) dut (
        .sys_clk_clk       (clk),
        .sys_reset_reset_n (rst_n),
        .req_mode          (req_mode),
        .req_valid         (req_valid),
        .busy              (busy),
        .applied_mode      (applied_mode),
        .done_pulse        (done_pulse),
        .err               (err),
        .frame_count       (frame_count),
        .mon_valid         (mon_valid),
        .mon_ready         (mon_ready),
        .mon_sop           (mon_sop),
        .mon_eop           (mon_eop),
        .ctrl              (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Control-slave responder: stores writes, echoes them back unless told to corrupt
    ctrl_word_t slave_reg = '0;
    logic       stuck = 1'b0;
    logic       rd_fault = 1'b0;
    always @(posedge clk) if (bus.ctrl_chipselect && !bus.ctrl_write_n) slave_reg <= bus.ctrl_writedata;
    assign bus.ctrl_readdata = stuck ? 32'h0 : (slave_reg ^ {31'b0, rd_fault});

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    int         wr_cyc[$];
    ctrl_word_t wr_dat[$];
    int         rd_cyc[$];
    int         done_cyc[$];

    function automatic int wr_at(input int i);
        return (i < wr_cyc.size()) ? wr_cyc[i] : -1;
    endfunction
    function automatic int wd_at(input int i);
        return (i < wr_dat.size()) ? int'(wr_dat[i]) : -1;
    endfunction
    function automatic int rd_at(input int i);
        return (i < rd_cyc.size()) ? rd_cyc[i] : -1;
    endfunction
    function automatic int dn_at(input int i);
        return (i < done_cyc.size()) ? done_cyc[i] : -1;
    endfunction

    task automatic clear_logs();
        wr_cyc.delete(); wr_dat.delete(); rd_cyc.delete(); done_cyc.delete();
    endtask

    // Transaction-level reference: phase 0 idle, 1 awaiting boundary, 2 access sequence
    // timed as an offset from the cycle of its WRITE.
    int          m_phase = 0;
    int          m_t0 = 0;
    int          m_att = 0;
    logic        m_pv = 1'b0;
    ctrl_word_t  m_pw = '0;
    ctrl_word_t  m_word = '0;
    ctrl_word_t  m_rd = '0;
    ctrl_word_t  m_applied = '0;
    logic        m_err = 1'b0;
    logic        m_infr = 1'b0;
    logic [15:0] m_fc = '0;

    always @(negedge clk) begin
        int   off;
        logic sop_b, eop_b, fa, consume, err_set, exp_cs, exp_wr, exp_done;
        if (!rst_n) begin
            m_phase = 0; m_t0 = 0; m_att = 0; m_pv = 1'b0; m_pw = '0; m_word = '0; m_rd = '0;
            m_applied = '0; m_err = 1'b0; m_infr = 1'b0; m_fc = '0;
            chk("rst_chipselect", bus.ctrl_chipselect, 0);
            chk("rst_write_n", bus.ctrl_write_n, 1);
            chk("rst_busy", busy, 0);
            chk("rst_done", done_pulse, 0);
            chk("rst_err", err, 0);
            chk("rst_applied", applied_mode, 0);
            chk("rst_frame_count", frame_count, 0);
        end else begin
            off      = cyc - m_t0;
            exp_cs   = (m_phase == 2) && (off == 0 || off == 1);
            exp_wr   = (m_phase == 2) && (off == 0);
            exp_done = (m_phase == 2) && (off == 2 + L) && (m_rd == m_word);
            chk("chipselect", bus.ctrl_chipselect, exp_cs);
            chk("write_n", bus.ctrl_write_n, !exp_wr);
            if (exp_cs) chk("address", bus.ctrl_address, ADDR);
            if (exp_wr) chk("writedata", bus.ctrl_writedata, m_word);
            chk("busy", busy, (m_phase != 0) || m_pv);
            chk("done_pulse", done_pulse, exp_done);
            chk("err", err, m_err);
            chk("applied_mode", applied_mode, m_applied);
            chk("frame_count", frame_count, m_fc);
            if (bus.ctrl_chipselect && !bus.ctrl_write_n) begin
                wr_cyc.push_back(cyc);
                wr_dat.push_back(bus.ctrl_writedata);
            end
            if (bus.ctrl_chipselect && bus.ctrl_write_n) rd_cyc.push_back(cyc);
            if (done_pulse) done_cyc.push_back(cyc);

            sop_b   = mon_valid && mon_ready && mon_sop;
            eop_b   = mon_valid && mon_ready && mon_eop;
            fa      = m_infr || sop_b;
            consume = 1'b0;
            err_set = 1'b0;
            case (m_phase)
                0: if (m_pv) begin
                       if (!fa) consume = 1'b1;
                       else m_phase = 1;
                   end
                1: if (eop_b) consume = 1'b1;
                default: begin
                    if (off == 1 + L) m_rd = bus.ctrl_readdata;
                    if (off == 2 + L) begin
                        if (m_rd == m_word) begin
                            m_applied = m_word;
                            m_phase = 0;
                        end else if (m_att < MAXR) begin
                            m_att++;
                            m_t0 = cyc + 1;
                        end else begin
                            err_set = 1'b1;
                            m_phase = 0;
                        end
                    end
                end
            endcase
            if (consume) begin
                m_word = m_pw; m_t0 = cyc + 1; m_att = 0; m_phase = 2; m_pv = 1'b0;
            end
            if (req_valid) begin
                m_pv = 1'b1;
                m_pw = req_mode;
            end
            if (err_set) m_err = 1'b1;
            else if (req_valid) m_err = 1'b0;
            if (eop_b) m_infr = 1'b0;
            else if (sop_b) m_infr = 1'b1;
            if (eop_b) m_fc = m_fc + 16'd1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    task automatic req(input ctrl_word_t v);
        req_valid = 1'b1;
        req_mode  = v;
        step();
        req_valid = 1'b0;
    endtask

    task automatic mon_beat(input logic sop, input logic eop);
        mon_valid = 1'b1; mon_ready = 1'b1; mon_sop = sop; mon_eop = eop;
        step();
        mon_valid = 1'b0; mon_ready = 1'b0; mon_sop = 1'b0; mon_eop = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        chk("idle_timeout", busy, 0);
        repeat (2) step();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int s;

        repeat (3) step();
        chk("reset_chipselect", bus.ctrl_chipselect, 0);
        chk("reset_write_n", bus.ctrl_write_n, 1);
        chk("reset_busy", busy, 0);
        rst_n = 1'b1;
        step();

        // Idle stream: WRITE at +2, READ at +3, done at +5
        clear_logs();
        c0 = cyc;
        req(32'h1);
        wait_idle(100);
        chk("idle_wr_count", wr_cyc.size(), 1);
        chk("idle_wr_cycle", wr_at(0), c0 + 2);
        chk("idle_wr_data", wd_at(0), 32'h1);
        chk("idle_rd_cycle", rd_at(0), c0 + 3);
        chk("idle_done_cycle", dn_at(0), c0 + 5);
        chk("idle_applied", applied_mode, 32'h1);
        chk("idle_err", err, 0);

        // Mid-frame request held until the EOP beat at +40
        clear_logs();
        s = cyc;
        mon_beat(1'b1, 1'b0);
        goto(s + 10);
        req(32'h3);
        goto(s + 40);
        mon_beat(1'b0, 1'b1);
        wait_idle(100);
        chk("frame_wr_count", wr_cyc.size(), 1);
        chk("frame_wr_cycle", wr_at(0), s + 41);
        chk("frame_first_read", rd_at(0), s + 42);
        chk("frame_count_one", frame_count, 16'd1);
        chk("frame_applied", applied_mode, 32'h3);

        // Read-back stuck at zero: three attempts then sticky error
        clear_logs();
        stuck = 1'b1;
        c0 = cyc;
        req(32'h2);
        wait_idle(200);
        stuck = 1'b0;
        chk("stuck_wr_count", wr_cyc.size(), 3);
        chk("stuck_rd_count", rd_cyc.size(), 3);
        chk("stuck_third_wr", wr_at(2), c0 + 10);
        chk("stuck_third_data", wd_at(2), 32'h2);
        chk("stuck_done_count", done_cyc.size(), 0);
        chk("stuck_err", err, 1);
        chk("stuck_applied", applied_mode, 32'h3);
        chk("stuck_busy", busy, 0);

        // Overwrite while waiting for EOP, then a request landing during READ
        clear_logs();
        mon_beat(1'b1, 1'b0);
        s = cyc;
        req(32'h1);
        goto(s + 3);
        req(32'h2);
        goto(s + 8);
        mon_beat(1'b0, 1'b1);
        goto(s + 10);
        req(32'h3);
        wait_idle(100);
        chk("ovw_wr_count", wr_cyc.size(), 2);
        chk("ovw_wr0_cycle", wr_at(0), s + 9);
        chk("ovw_wr0_data", wd_at(0), 32'h2);
        chk("ovw_done0", dn_at(0), s + 12);
        chk("ovw_wr1_cycle", wr_at(1), s + 14);
        chk("ovw_wr1_data", wd_at(1), 32'h3);
        chk("ovw_done1", dn_at(1), s + 17);
        chk("ovw_err_cleared", err, 0);

        // Single-beat frame leaves the stream idle, so a request goes straight out
        clear_logs();
        s = cyc;
        mon_beat(1'b1, 1'b1);
        req(32'h5);
        wait_idle(100);
        chk("single_wr_cycle", wr_at(0), s + 3);
        chk("single_frame_count", frame_count, 16'd3);
        chk("single_applied", applied_mode, 32'h5);

        // Randomized traffic against the reference
        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom_range(0, 15) == 0);
            req_mode  = $urandom;
            mon_valid = 1'($urandom_range(0, 1));
            mon_ready = 1'($urandom_range(0, 1));
            mon_sop   = ($urandom_range(0, 7) == 0);
            mon_eop   = ($urandom_range(0, 7) == 0);
            rd_fault  = ($urandom_range(0, 5) == 0);
            step();
        end
        req_valid = 1'b0; mon_valid = 1'b0; mon_ready = 1'b0; mon_sop = 1'b0; mon_eop = 1'b0;
        rd_fault = 1'b0;
        repeat (4) step();
        mon_beat(1'b0, 1'b1);
        wait_idle(500);

        // Reset during WRITE and during WAIT_RD
        for (int k = 0; k < 2; k++) begin
            clear_logs();
            c0 = cyc;
            req(32'h7);
            goto(c0 + ((k == 0) ? 2 : 4));
            #1;
            rst_n = 1'b0;
            #1;
            chk("arst_chipselect", bus.ctrl_chipselect, 0);
            chk("arst_write_n", bus.ctrl_write_n, 1);
            chk("arst_busy", busy, 0);
            step();
            step();
            rst_n = 1'b1;
            clear_logs();
            repeat (20) step();
            chk("arst_no_done", done_cyc.size(), 0);
            chk("arst_no_write", wr_cyc.size(), 0);
            chk("arst_idle", busy, 0);
        end

        // Frame counter wrap
        mon_valid = 1'b1; mon_ready = 1'b1; mon_eop = 1'b1;
        repeat (65535) step();
        chk("wrap_ffff", frame_count, 16'hFFFF);
        step();
        chk("wrap_zero", frame_count, 16'h0000);
        mon_valid = 1'b0; mon_ready = 1'b0; mon_eop = 1'b0;
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/edge_ctrl_sequencer.md
# edge_ctrl_sequencer

Frame-synchronous configuration sequencer for the edge-detection subsystem's 2-bit-address Avalon-MM control slave. It accepts mode-change requests from the host side and holds each one until the video stream passes a frame boundary. It then writes the new value to the control slave, reads it back, and retries or flags an error on mismatch. It sits between the system control logic and the subsystem's control slave, and passively taps the subsystem's video sink handshake.

## Interface
Parameters:
- CTRL_ADDR, 2'd0: control-slave register address targeted for write and read-back.
- READ_LATENCY, 1: cycles from the read command (chipselect=1, write_n=1) to valid ctrl_readdata; legal range 1..3.
- MAX_RETRY, 2: write/read-back retries after the first attempt before declaring an error.
- FRAME_CNT_W, 16: width of the frame counter.

Ports:
- sys_clk_clk  in  1  single clock.
- sys_reset_reset_n  in  1  reset, asynchronous, active-low.
- req_mode  in  32  requested control word.
- req_valid  in  1  one-cycle strobe; req_mode is sampled on it.
- busy  out  1  request pending or in progress.
- applied_mode  out  32  last value verified by read-back.
- done_pulse  out  1  one cycle, on successful verify.
- err  out  1  sticky; set when retries are exhausted; cleared by the next accepted req_valid.
- frame_count  out  FRAME_CNT_W  completed frames, counted on EOP beats.
- mon_valid, mon_ready, mon_sop, mon_eop  in  1 each  tap of the video sink handshake.
- ctrl_address  out  2  master address.
- ctrl_write_n  out  1  active-low write.
- ctrl_writedata  out  32  write data.
- ctrl_chipselect  out  1  access strobe.
- ctrl_readdata  in  32  read data.

## Operation
- Beat definition: beat = mon_valid & mon_ready. sop_beat = beat & mon_sop. eop_beat = beat & mon_eop.
- in_frame register: set on sop_beat, cleared on eop_beat. If both occur in the same cycle (a single-beat frame), in_frame ends at 0.
- frame_active = in_frame | sop_beat.
- Pending register: req_valid loads the pending word and clears err. A new req_valid while busy overwrites the pending word. That word is applied after the current transaction completes; intermediate requests are dropped.
- State machine states: IDLE, WAIT_EOP, WRITE, READ, WAIT_RD, CHECK.
  - IDLE: if a request is pending, go to WRITE when frame_active=0, else go to WAIT_EOP.
  - WAIT_EOP: on eop_beat, go to WRITE. The EOP cycle itself counts as the boundary.
  - WRITE: one cycle with chipselect=1, write_n=0, address=CTRL_ADDR, writedata=pending word. Go to READ.
  - READ: one cycle with chipselect=1, write_n=1. Go to WAIT_RD.
  - WAIT_RD: stay READ_LATENCY cycles; capture ctrl_readdata on the last one. Go to CHECK.
  - CHECK (compare readback against the written word):
    - match: applied_mode is updated, done_pulse fires, and the FSM goes to IDLE.
    - mismatch with retry count < MAX_RETRY: increment the retry count and go to WRITE. The retry does not wait for a new boundary.
    - mismatch otherwise: set err, leave applied_mode unchanged, and go to IDLE.
- The retry count clears on each new transaction start.
- An overwrite that arrives during WRITE through CHECK does not alter the word in flight. It keeps busy=1 and starts a new transaction from IDLE afterwards.
- busy = (state≠IDLE) | pending_valid.
- frame_count increments on every eop_beat and wraps modulo 2^FRAME_CNT_W.

## Timing
- Reset values:
  - Every output is 0, except ctrl_write_n=1.
  - State is IDLE, in_frame=0, and no request is pending.
- ctrl_* outputs are registered, glitch-free, and asserted for exactly one cycle per access.
- chipselect is 0 in all states other than WRITE and READ.
- Latency with the stream idle (req_valid at cycle 0, READ_LATENCY=1):
  - IDLE sees the pending request at cycle 1.
  - WRITE at cycle 2, READ at cycle 3, readdata sampled at cycle 4.
  - done_pulse at cycle 5.
- Frame-synchronous case: WRITE occurs in the cycle after eop_beat.
- Reset asserted mid-transaction: the FSM aborts immediately, the pending request is lost, and ctrl_chipselect drops asynchronously.
- Monitor inputs are sampled only; the block never drives the stream.

## Structure
- Shared package edge_ctrl_pkg:
  - state enum edge_ctrl_state_t.
  - CTRL_ADDR_MODE default constant.
  - 32-bit control word typedef.
- One natural sub-module, edge_frame_tracker: holds in_frame, frame_active, eop_beat, and frame_count.
- The FSM and the Avalon master live in the top.

## Test plan
- Idle stream: req_mode=0x1, readdata echoes the written value.
  - One write then one read, address 0.
  - done_pulse at cycle 5; applied_mode=0x1; err=0.
- Mid-frame request: sop_beat, then req_mode=0x3 ten cycles later, eop_beat at cycle 40.
  - No chipselect before cycle 41.
  - WRITE at cycle 41; frame_count=1.
- Read-back stuck at 0x0 for req_mode=0x2, MAX_RETRY=2.
  - Exactly 3 write/read pairs.
  - err=1; applied_mode unchanged; busy=0 afterwards.
- Overwrite: req 0x1 then req 0x2 while in WAIT_EOP.
  - Only 0x2 is written, at the next boundary.
  - Then a req 0x3 arriving during READ produces a second transaction of 0x3 immediately after the first done_pulse.
- Edge cases: a single-beat frame (SOP and EOP in the same beat) leaves in_frame=0; frame_count wraps 0xFFFF→0 with FRAME_CNT_W=16.
- Reset asserted in WAIT_RD: all outputs return to reset values asynchronously, and no done_pulse follows the release of reset.
